branch_unit_bht: RTL and testbench

//  Parametrised branch resolution unit with a dynamic predictor. It resolves

---
 rtl/branch_unit_bht.sv | 119 +++++++++++
 tb/tb_branch_unit_bht.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit_bht.sv
// Branch resolution unit with a PC-indexed table of saturating counters.
// It resolves SB-type branches in EX, predicts for IF, and keeps branch/mispredict statistics.
module branch_unit_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_BITS    = 2,
    parameter int STAT_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 if_pred_taken,
    input  logic                 ex_valid,
    input  logic [31:0]          ex_instr,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [XLEN-1:0]      ex_rs1,
    input  logic [XLEN-1:0]      ex_rs2,
    input  logic [XLEN-1:0]      ex_target,
    input  logic                 ex_pred_taken,
    input  logic                 flush,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 mispredict,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispred
);

    localparam int IDX_BITS = $clog2(BHT_ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_MAX >> 1;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [CNT_BITS-1:0]  r_bht [BHT_ENTRIES];
    logic                 r_resValid;
    logic                 r_resTaken;
    logic                 r_mispredict;
    logic [XLEN-1:0]      r_redirectPc;
    logic [STAT_BITS-1:0] r_statBranches;
    logic [STAT_BITS-1:0] r_statMispred;

    logic [IDX_BITS-1:0]  w_ifIdx;
    logic [IDX_BITS-1:0]  w_exIdx;
    logic                 w_isBranch;
    logic                 w_outcome;
    logic                 w_resolve;
    logic                 w_mispredict;
    logic [CNT_BITS-1:0]  w_exCnt;
    logic [CNT_BITS-1:0]  w_nextCnt;
    logic                 w_unused;

    assign w_ifIdx  = if_pc[IDX_BITS+1:2];
    assign w_exIdx  = ex_pc[IDX_BITS+1:2];
    assign w_unused = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0], ex_pc[1:0],
                        ex_instr[31:15], ex_instr[11:7]};

    always_comb begin
        w_isBranch = 1'b0;
        w_outcome  = 1'b0;
        if (ex_instr[6:0] == OPC_BRANCH) begin
            case (ex_instr[14:12])
                3'b000: begin w_isBranch = 1'b1; w_outcome = (ex_rs1 == ex_rs2); end
                3'b001: begin w_isBranch = 1'b1; w_outcome = (ex_rs1 != ex_rs2); end
                3'b100: begin w_isBranch = 1'b1; w_outcome = ($signed(ex_rs1) <  $signed(ex_rs2)); end
                3'b101: begin w_isBranch = 1'b1; w_outcome = ($signed(ex_rs1) >= $signed(ex_rs2)); end
                3'b110: begin w_isBranch = 1'b1; w_outcome = (ex_rs1 <  ex_rs2); end
                3'b111: begin w_isBranch = 1'b1; w_outcome = (ex_rs1 >= ex_rs2); end
                default: ;
            endcase
        end
    end

    assign w_resolve    = ex_valid && !flush && w_isBranch;
    assign w_mispredict = (w_outcome != ex_pred_taken);
    assign w_exCnt      = r_bht[w_exIdx];

    always_comb begin
        w_nextCnt = w_exCnt;
        if (w_outcome) begin
            if (w_exCnt != CNT_MAX) w_nextCnt = w_exCnt + 1'b1;
        end else begin
            if (w_exCnt != '0) w_nextCnt = w_exCnt - 1'b1;
        end
    end

    // Prediction reads the registered table only; an update in the same cycle is seen next cycle.
    assign if_pred_taken = r_bht[w_ifIdx][CNT_BITS-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CNT_INIT;
            r_resValid     <= 1'b0;
            r_resTaken     <= 1'b0;
            r_mispredict   <= 1'b0;
            r_redirectPc   <= '0;
            r_statBranches <= '0;
            r_statMispred  <= '0;
        end else if (w_resolve) begin
            r_bht[w_exIdx] <= w_nextCnt;
            r_resValid     <= 1'b1;
            r_resTaken     <= w_outcome;
            r_mispredict   <= w_mispredict;
            r_redirectPc   <= w_outcome ? ex_target : ex_pc + XLEN'(4);
            if (r_statBranches != '1) r_statBranches <= r_statBranches + 1'b1;
            if (w_mispredict && r_statMispred != '1) r_statMispred <= r_statMispred + 1'b1;
        end else begin
            r_resValid   <= 1'b0;
            r_mispredict <= 1'b0;
        end
    end

    assign res_valid     = r_resValid;
    assign res_taken     = r_resTaken;
    assign mispredict    = r_mispredict;
    assign redirect_pc   = r_redirectPc;
    assign stat_branches = r_statBranches;
    assign stat_mispred  = r_statMispred;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Randomized and directed bench for branch_unit_bht, checked against an array-based predictor model.
// A second instance with 4-bit statistics shares the stimulus to exercise counter saturation.
module tb_branch_unit_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc, ex_instr, ex_pc, ex_rs1, ex_rs2, ex_target;
    logic        ex_valid, ex_pred_taken, flush;

    logic        if_pred_taken, res_valid, res_taken, mispredict;
    logic [31:0] redirect_pc, stat_branches, stat_mispred;
    logic        satPred, satResValid, satResTaken, satMispredict;
    logic [31:0] satRedirect;
    logic [3:0]  satStatBranches, satStatMispred;

    int     compareCount  = 0;
    int     mismatchCount = 0;
    int     cnt [64];
    longint statB, statM, statB4, statM4;
    logic        expResValid, expResTaken, expMisp;
    logic [31:0] expRedirect;

    always #5 clk = ~clk;

    branch_unit_bht dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .flush(flush), .res_valid(res_valid), .res_taken(res_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    branch_unit_bht #(.STAT_BITS(4)) dutSat (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(satPred),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .flush(flush), .res_valid(satResValid), .res_taken(satResTaken),
        .mispredict(satMispredict), .redirect_pc(satRedirect),
        .stat_branches(satStatBranches), .stat_mispred(satStatMispred)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] makeInstr(input logic [2:0] f3, input logic [6:0] op);
        logic [31:0] r;
        r = $urandom;
        r[14:12] = f3;
        r[6:0]   = op;
        return r;
    endfunction

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic logic modelPred(input logic [31:0] pc);
        return cnt[idxOf(pc)] >= 2;
    endfunction

    task automatic resetModel();
        foreach (cnt[i]) cnt[i] = 1;
        statB = 0; statM = 0; statB4 = 0; statM4 = 0;
        expResValid = 0; expResTaken = 0; expMisp = 0; expRedirect = 0;
    endtask

    task automatic checkRegistered();
        checkOutput("res_valid", res_valid, expResValid);
        checkOutput("res_taken", res_taken, expResTaken);
        checkOutput("mispredict", mispredict, expMisp);
        checkOutput("redirect_pc", redirect_pc, expRedirect);
        checkOutput("stat_branches", stat_branches, statB);
        checkOutput("stat_mispred", stat_mispred, statM);
        checkOutput("stat4_branches", satStatBranches, statB4);
        checkOutput("stat4_mispred", satStatMispred, statM4);
    endtask

    // Called at a falling edge; drives one cycle, checks the prediction, then the registered result.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                                 input logic pred, input logic fl, input logic [31:0] ifPc);
        logic [2:0] f3;
        logic       resolve, outcome;
        int         k;
        ex_valid = v; ex_instr = instr; ex_pc = pc; ex_rs1 = a; ex_rs2 = b;
        ex_target = tgt; ex_pred_taken = pred; flush = fl; if_pc = ifPc;
        #1;
        checkOutput("if_pred_taken", if_pred_taken, modelPred(ifPc));
        f3 = instr[14:12];
        resolve = v && !fl && instr[6:0] == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3;
        outcome = 1'b0;
        case (f3)
            3'd0: outcome = (a == b);
            3'd1: outcome = (a != b);
            3'd4: outcome = (int'(a) <  int'(b));
            3'd5: outcome = (int'(a) >= int'(b));
            3'd6: outcome = (longint'(a) <  longint'(b));
            3'd7: outcome = (longint'(a) >= longint'(b));
            default: ;
        endcase
        if (resolve) begin
            k = idxOf(pc);
            cnt[k] = outcome ? ((cnt[k] + 1 > 3) ? 3 : cnt[k] + 1)
                             : ((cnt[k] - 1 < 0) ? 0 : cnt[k] - 1);
            expResValid = 1;
            expResTaken = outcome;
            expMisp     = (outcome != pred);
            expRedirect = outcome ? tgt : pc + 32'd4;
            statB  = (statB  + 1 > 64'hFFFF_FFFF) ? statB  : statB + 1;
            statB4 = (statB4 + 1 > 15) ? 15 : statB4 + 1;
            if (outcome != pred) begin
                statM  = (statM  + 1 > 64'hFFFF_FFFF) ? statM : statM + 1;
                statM4 = (statM4 + 1 > 15) ? 15 : statM4 + 1;
            end
        end else begin
            expResValid = 0;
            expMisp     = 0;
        end
        @(posedge clk);
        #1;
        checkRegistered();
        @(negedge clk);
    endtask

    // Reset is asserted with whatever EX inputs are currently driven, so an in-flight branch is discarded.
    task automatic doReset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        resetModel();
        checkRegistered();
        checkOutput("pred_after_reset", if_pred_taken, modelPred(if_pc));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [6:0] OPB = 7'b1100011;

    initial begin
        logic [31:0] pcs [5];
        logic [31:0] pc, a, b;
        logic [6:0]  op;
        pcs = '{32'h100, 32'h104, 32'h200, 32'h300, 32'h0};
        rst_n = 1'b0; if_pc = 32'h100; ex_valid = 0; ex_instr = 0; ex_pc = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_target = 0; ex_pred_taken = 0; flush = 0;
        @(negedge clk);
        doReset();
        checkOutput("t1_pred_0x100", if_pred_taken, 1'b0);

        applyStimulus(1, makeInstr(3'd0, OPB), 32'h100, 5, 5, 32'h80, 0, 0, 32'h100);
        checkOutput("t2_redirect", redirect_pc, 32'h80);
        checkOutput("t2_mispredict", mispredict, 1'b1);
        applyStimulus(0, 32'h13, 32'h0, 0, 0, 0, 0, 0, 32'h100);
        checkOutput("t2_pred_now_taken", if_pred_taken, 1'b1);

        applyStimulus(1, makeInstr(3'd4, OPB), 32'h104, 32'hFFFF_FFFF, 1, 32'h40, 0, 0, 32'h104);
        checkOutput("t3_blt_taken", res_taken, 1'b1);
        applyStimulus(1, makeInstr(3'd6, OPB), 32'h104, 32'hFFFF_FFFF, 1, 32'h40, 1, 0, 32'h104);
        checkOutput("t3_bltu_redirect", redirect_pc, 32'h108);

        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1, makeInstr(3'd0, OPB), 32'h200, 7, 7, 32'h10, 1, 0, 32'h200);
        applyStimulus(1, makeInstr(3'd1, OPB), 32'h200, 7, 7, 32'h10, 1, 0, 32'h200);
        applyStimulus(0, 32'h13, 32'h0, 0, 0, 0, 0, 0, 32'h200);
        checkOutput("t4_pred_stays", if_pred_taken, 1'b1);

        doReset();
        applyStimulus(1, makeInstr(3'd1, OPB), 32'h300, 1, 2, 32'h20, 0, 1, 32'h300);
        applyStimulus(1, makeInstr(3'd2, OPB), 32'h300, 1, 1, 32'h20, 0, 0, 32'h300);
        checkOutput("t5_no_stats", stat_branches, 32'd0);
        applyStimulus(1, makeInstr(3'd0, OPB), 32'h300, 3, 3, 32'h20, 0, 0, 32'h300);
        applyStimulus(0, 32'h13, 32'h0, 0, 0, 0, 0, 0, 32'h300);
        checkOutput("t5_alias_updated", if_pred_taken, 1'b1);

        doReset();
        for (int i = 0; i < 20; i++)
            applyStimulus(1, makeInstr(3'd0, OPB), 32'h100 + 32'(i * 4), 9, 9, 32'h400, 0, 0, 32'h100);
        checkOutput("t6_stat4_sat", satStatMispred, 4'hF);
        checkOutput("t6_stat32", stat_mispred, 32'd20);
        ex_valid = 1; ex_instr = makeInstr(3'd0, OPB); ex_rs1 = 1; ex_rs2 = 1; if_pc = 32'h100;
        doReset();

        for (int n = 0; n < 400; n++) begin
            pc = ($urandom_range(0, 4) == 4) ? ($urandom & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 3)];
            a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : 32'($urandom_range(0, 4)) - 32'd2;
            op = ($urandom_range(0, 9) == 0) ? 7'b0110011 : OPB;
            if ($urandom_range(0, 99) == 0) begin
                ex_valid = 1; ex_instr = makeInstr(3'd0, OPB); ex_pc = pc;
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 9) != 0, makeInstr(3'($urandom_range(0, 7)), op),
                              pc, a, b, $urandom, 1'($urandom_range(0, 1)),
                              $urandom_range(0, 9) == 0, pcs[$urandom_range(0, 3)]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
